// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: frames bytes from the serdes, decodes a R/W+address
// command byte, and streams register-file writes/reads with address auto-increment.
module spi_reg_ctrl #(
  parameter int NUM_REGS = 16,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic       spi_clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       pico,
  input  logic [7:0] byte_deser,
  input  logic [7:0] reg_rdata,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  output logic       poci,
  output logic       addr_err
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  state_t     state, state_next;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic       wr_adv;
  logic [7:0] full_byte;
  logic       addr_ok;
  logic [6:0] addr_inc;
  logic       deser_msb_unused;

  // The serdes has already shifted out its MSB by the time bit 7 arrives.
  assign deser_msb_unused = byte_deser[7];
  assign full_byte        = {byte_deser[6:0], pico};
  assign addr_ok          = {1'b0, reg_addr} < NUM_REGS_W;
  assign addr_inc         = !AUTO_INC ? reg_addr :
                            (reg_addr == LAST_ADDR) ? 7'd0 : reg_addr + 7'd1;
  assign poci             = tx_shift[7];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (!cs) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = CMD;
        CMD:     if (bit_cnt == 3'd7) state_next = full_byte[7] ? WRITE : READ;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge spi_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      tx_shift  <= '0;
      addr_err  <= 1'b0;
      wr_adv    <= 1'b0;
    end else if (!cs) begin
      bit_cnt   <= '0;
      tx_shift  <= '0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      wr_adv    <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt + 3'd1;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      case (state)
        CMD: if (bit_cnt == 3'd7) reg_addr <= full_byte[6:0];
        WRITE: begin
          // Address moves only after the strobe cycle so the regfile sees the right address.
          if (wr_adv) begin
            reg_addr <= addr_inc;
            wr_adv   <= 1'b0;
          end
          if (bit_cnt == 3'd7) begin
            wr_adv <= 1'b1;
            if (addr_ok) begin
              reg_wdata <= full_byte;
              reg_wr_en <= 1'b1;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        READ: begin
          if (bit_cnt == 3'd0) begin
            if (addr_ok) begin
              tx_shift  <= reg_rdata;
              reg_rd_en <= 1'b1;
            end else begin
              tx_shift <= '0;
              addr_err <= 1'b1;
            end
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
          if (bit_cnt == 3'd7) reg_addr <= addr_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: bench-side serdes and 16-entry register file,
// hand-computed expectations checked with immediate assertions.
module tb_spi_reg_ctrl;

  logic       spi_clk = 1'b0;
  logic       rst, cs, pico;
  logic [7:0] byte_deser = 8'h00;
  logic [7:0] reg_rdata;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en, reg_rd_en, poci, addr_err;

  logic [7:0]  regs [16];
  logic [14:0] wr_log [$];
  logic [6:0]  rd_log [$];
  int          both_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] stream;

  spi_reg_ctrl #(.NUM_REGS(16), .AUTO_INC(1'b1)) dut (
    .spi_clk    (spi_clk),
    .rst        (rst),
    .cs         (cs),
    .pico       (pico),
    .byte_deser (byte_deser),
    .reg_rdata  (reg_rdata),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .poci       (poci),
    .addr_err   (addr_err)
  );

  always #5 spi_clk = ~spi_clk;

  assign reg_rdata = (reg_addr < 7'd16) ? regs[reg_addr[3:0]] : 8'hEE;

  // Serdes shift register and register file live on the bench side.
  always @(posedge spi_clk) begin
    if (cs) byte_deser <= {byte_deser[6:0], pico};
    if (reg_wr_en) begin
      regs[reg_addr[3:0]] <= reg_wdata;
      wr_log.push_back({reg_addr, reg_wdata});
    end
    if (reg_rd_en) rd_log.push_back(reg_addr);
    if (reg_wr_en && reg_rd_en) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge spi_clk);
  endtask

  // Drives the first n bits of b MSB-first, one per negedge.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      cs   = 1'b1;
      pico = b[7-i];
    end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; pico = 1'b0;
    tick(); tick();
    check("rst_addr",  32'(reg_addr),  0);
    check("rst_wdata", 32'(reg_wdata), 0);
    check("rst_wr_en", 32'(reg_wr_en), 0);
    check("rst_rd_en", 32'(reg_rd_en), 0);
    check("rst_poci",  32'(poci),      0);
    check("rst_err",   32'(addr_err),  0);
    rst = 1'b0;
    tick();

    // Single write 0x83, 0x5A
    send_bits(8'h83, 8);
    send_bits(8'h5A, 8);
    tick();
    check("wr1_en",   32'(reg_wr_en), 1);
    check("wr1_addr", 32'(reg_addr),  3);
    check("wr1_data", 32'(reg_wdata), 'h5A);
    cs = 1'b0; pico = 1'b0;
    tick();
    check("wr1_en_off", 32'(reg_wr_en), 0);
    check("wr1_addr_hold", 32'(reg_addr), 3);
    check("wr1_state", 32'(dut.state), 0);
    check("wr1_err", 32'(addr_err), 0);
    check("wr1_log_n", wr_log.size(), 1);
    if (wr_log.size() >= 1) check("wr1_log0", 32'(wr_log[0]), 'h35A);
    tick();

    // Burst with wrap 15 -> 0 -> 1
    send_bits(8'h8F, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 8);
    tick();
    cs = 1'b0; pico = 1'b0;
    tick();
    check("burst_log_n", wr_log.size(), 4);
    if (wr_log.size() >= 4) begin
      check("burst_w0", 32'(wr_log[1]), 'hF11);
      check("burst_w1", 32'(wr_log[2]), 'h022);
      check("burst_w2", 32'(wr_log[3]), 'h133);
    end
    check("burst_addr_end", 32'(reg_addr), 1);
    tick();

    // Preload register 2 through the interface
    send_bits(8'h82, 8);
    send_bits(8'hA5, 8);
    tick();
    cs = 1'b0; pico = 1'b0;
    tick();
    check("wr2_log_n", wr_log.size(), 5);
    if (wr_log.size() >= 5) check("wr2_log", 32'(wr_log[4]), 'h2A5);
    tick();

    // Read from 2: expect A5 then regs[3]=5A on poci
    send_bits(8'h02, 8);
    tick();
    check("rd_pre_en", 32'(reg_rd_en), 0);
    check("rd_addr",   32'(reg_addr),  2);
    stream = '0;
    for (int j = 0; j < 16; j++) begin
      cs = 1'b1; pico = 1'b1;
      tick();
      stream = {stream[14:0], poci};
      if (j == 0) check("rd_en_first", 32'(reg_rd_en), 1);
      if (j == 1) check("rd_en_single", 32'(reg_rd_en), 0);
      if (j == 8) begin
        check("rd_en_second", 32'(reg_rd_en), 1);
        check("rd_addr_next", 32'(reg_addr), 3);
      end
    end
    check("rd_stream", 32'(stream), 'hA55A);
    cs = 1'b0; pico = 1'b0;
    tick();
    check("rd_poci_idle", 32'(poci), 0);
    check("rd_log_n", rd_log.size(), 2);
    if (rd_log.size() >= 2) begin
      check("rd_log0", 32'(rd_log[0]), 2);
      check("rd_log1", 32'(rd_log[1]), 3);
    end
    check("rd_no_wr", wr_log.size(), 5);
    tick();

    // Out-of-range write to 16, then a clean frame
    send_bits(8'h90, 8);
    send_bits(8'hFF, 8);
    tick();
    check("oor_wr_en", 32'(reg_wr_en), 0);
    check("oor_err",   32'(addr_err),  1);
    check("oor_addr",  32'(reg_addr),  'h10);
    cs = 1'b0; pico = 1'b0;
    tick();
    check("oor_log_n", wr_log.size(), 5);
    tick();
    send_bits(8'h84, 8);
    send_bits(8'h66, 8);
    tick();
    cs = 1'b0; pico = 1'b0;
    tick();
    check("oor_clean_log_n", wr_log.size(), 6);
    if (wr_log.size() >= 6) check("oor_clean_log", 32'(wr_log[5]), 'h466);
    check("oor_err_sticky", 32'(addr_err), 1);
    tick();

    // Abort after 5 data bits, then a good frame
    send_bits(8'h85, 8);
    send_bits(8'h77, 5);
    tick();
    cs = 1'b0; pico = 1'b0;
    tick();
    check("abort_wr_en", 32'(reg_wr_en), 0);
    check("abort_state", 32'(dut.state), 0);
    check("abort_log_n", wr_log.size(), 6);
    tick();
    send_bits(8'h81, 8);
    send_bits(8'h07, 8);
    tick();
    cs = 1'b0; pico = 1'b0;
    tick();
    check("post_abort_log_n", wr_log.size(), 7);
    if (wr_log.size() >= 7) check("post_abort_log", 32'(wr_log[6]), 'h107);
    tick();

    // Reset during the second read byte
    send_bits(8'h02, 8);
    for (int j = 0; j < 11; j++) begin
      cs = 1'b1; pico = 1'b0;
      tick();
    end
    rst = 1'b1; cs = 1'b0;
    tick();
    check("rstrd_addr",  32'(reg_addr),  0);
    check("rstrd_wdata", 32'(reg_wdata), 0);
    check("rstrd_wr_en", 32'(reg_wr_en), 0);
    check("rstrd_rd_en", 32'(reg_rd_en), 0);
    check("rstrd_poci",  32'(poci),      0);
    check("rstrd_err",   32'(addr_err),  0);
    check("rstrd_state", 32'(dut.state), 0);
    rst = 1'b0;
    tick();

    check("never_both_strobes", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
